system_touch_panel_pen_conditioner: RTL

//  Conditions the raw active-low PENIRQ pin from the resistive touch-panel ADC

---
 rtl/system_touch_panel_pen_conditioner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/system_touch_panel_pen_conditioner.sv
// Conditions the raw active-low PENIRQ pin: 2-FF synchroniser, two-edge debounce, blanking plus hold-off.
// Latency: a stable raw change reaches pen_irq_n_out DEBOUNCE_CYCLES + 2 edges after the edge that first samples it.
// No backpressure: the pulses are fire-and-forget strobes, and sampling reports when the debouncer is listening.
module system_touch_panel_pen_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLDOFF_CYCLES  = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pen_irq_n_raw,
    input  logic blank,
    output logic pen_irq_n_out,
    output logic pen_down_pulse,
    output logic pen_up_pulse,
    output logic sampling
);

    localparam logic [1:0] ST_UP       = 2'd0;
    localparam logic [1:0] ST_DEB_DOWN = 2'd1;
    localparam logic [1:0] ST_DOWN     = 2'd2;
    localparam logic [1:0] ST_DEB_UP   = 2'd3;

    localparam logic [15:0] DEB_MAX  = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] HOLD_MAX = 16'(HOLDOFF_CYCLES);

    logic        sync1_q, sync2_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic        blank_q;
    logic        sampling_q, sampling_d;
    logic        out_q, out_d;
    logic        down_q, down_d;
    logic        up_q, up_d;

    // Two-flop synchroniser; it keeps running through blanking so s is fresh when sampling resumes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pen_irq_n_raw;
            sync2_q <= sync1_q;
        end
    end

    // Blank/hold-off tracker: the first low cycle of blank loads the hold-off, and sampling returns as it expires.
    always_comb begin
        hold_d     = hold_q;
        sampling_d = sampling_q;
        if (blank) begin
            hold_d     = 16'd0;
            sampling_d = 1'b0;
        end else if (blank_q) begin
            hold_d     = HOLD_MAX;
            sampling_d = (HOLD_MAX == 16'd0);
        end else if (hold_q != 16'd0) begin
            hold_d     = hold_q - 16'd1;
            sampling_d = (hold_q == 16'd1);
        end
    end

    // Debounce FSM. Blank aborts any partial count, and settled states are only evaluated while sampling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        down_d  = 1'b0;
        up_d    = 1'b0;
        if (blank) begin
            cnt_d = 16'd0;
            if (state_q == ST_DEB_DOWN) begin
                state_d = ST_UP;
            end else if (state_q == ST_DEB_UP) begin
                state_d = ST_DOWN;
            end
        end else if (sampling_q) begin
            case (state_q)
                ST_UP: begin
                    if (!sync2_q) begin
                        state_d = ST_DEB_DOWN;
                        cnt_d   = 16'd1;
                    end
                end
                ST_DEB_DOWN: begin
                    if (sync2_q) begin
                        state_d = ST_UP;
                        cnt_d   = 16'd0;
                    end else if (cnt_q == DEB_MAX) begin
                        state_d = ST_DOWN;
                        cnt_d   = 16'd0;
                        out_d   = 1'b0;
                        down_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_DOWN: begin
                    if (sync2_q) begin
                        state_d = ST_DEB_UP;
                        cnt_d   = 16'd1;
                    end
                end
                default: begin
                    if (!sync2_q) begin
                        state_d = ST_DOWN;
                        cnt_d   = 16'd0;
                    end else if (cnt_q == DEB_MAX) begin
                        state_d = ST_UP;
                        cnt_d   = 16'd0;
                        out_d   = 1'b1;
                        up_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // State and output registers; the pulses are registered so they line up with the output edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_UP;
            cnt_q      <= 16'd0;
            hold_q     <= 16'd0;
            blank_q    <= 1'b0;
            sampling_q <= 1'b1;
            out_q      <= 1'b1;
            down_q     <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            blank_q    <= blank;
            sampling_q <= sampling_d;
            out_q      <= out_d;
            down_q     <= down_d;
            up_q       <= up_d;
        end
    end

    assign pen_irq_n_out  = out_q;
    assign pen_down_pulse = down_q;
    assign pen_up_pulse   = up_q;
    assign sampling       = sampling_q;

endmodule
